vga_fb_bus_ctrl: RTL and testbench
==================================

Name: vga_fb_bus_ctrl

Overview:
- Parametrised successor to the single-bit VGA bus peripheral.
- Decodes a window of bus-mapped registers and drives the write port of the frame buffer.
- Adds multi-bit pixels, a cursor with auto-increment, a hardware clear/fill engine and status read-back.
- Sits between the microprocessor bus and the frame buffer. Colour config goes to the VGA signal generator.

Parameters:
- BASE_ADDR, 8'hB0, first bus address of the 6-register window (BASE+0..BASE+5).
- X_W, 8, width of X cursor.
- Y_W, 7, width of Y cursor.
- PIX_W, 1, pixel width in bits (1..8).
- X_MAX, 159, last valid X coordinate.
- Y_MAX, 119, last valid Y coordinate.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA  in  8  bus write data.
- BUS_WE  in  1  bus write strobe, one cycle per write.
- BUS_DATA_OUT  out  8  registered read data.
- BUS_DATA_OE  out  1  read-data valid / drive enable.
- FB_ADDR  out  X_W+Y_W  frame-buffer address {Y,X}.
- FB_DATA  out  PIX_W  frame-buffer write data.
- FB_WE  out  1  frame-buffer write enable.
- CONFIG_COL  out  16  colour configuration to signal generator.
- BUSY  out  1  fill engine active.

Behaviour:
- Reset (RESET=0, asynchronous): every register and output is 0; FSM goes to IDLE. This includes CONFIG_COL, cursor, FB_*, BUS_DATA_OUT/OE, BUSY, the DROP flag and AUTOINC.
- Register map (write = BUS_ADDR match & BUS_WE):
  - BASE+0 COLOUR: CONFIG_COL <= {D, ~D}.
  - BASE+1 X: X <= D[X_W-1:0].
  - BASE+2 Y: Y <= D[Y_W-1:0].
  - BASE+3 PIXEL: writes D[PIX_W-1:0] at {Y,X}.
  - BASE+4 CTRL: bit0 START fill; bit1 AUTOINC (level, stored); bit2 CLR_DROP.
  - BASE+5 FILL: FILL_VAL <= D[PIX_W-1:0].
- Pixel write:
  - FB_ADDR={Y,X}, FB_DATA and FB_WE=1 are registered: valid the cycle after the bus write, FB_WE high for exactly 1 cycle.
  - If AUTOINC=1, the cursor advances in the same edge. X+1; when X==X_MAX, X<=0 and Y+1; when Y==Y_MAX, Y<=0 as well (full-frame wrap).
  - With AUTOINC=0 the cursor is unchanged.
- Out-of-range cursor (X>X_MAX or Y>Y_MAX) on a PIXEL write: the write is suppressed (FB_WE stays 0) and DROP is set. With AUTOINC=1, X<=0 and Y<=0.
- Fill FSM:
  - IDLE: START=1 -> FILL. Fill counters load 0, BUSY<=1.
  - FILL: each cycle FB_WE=1, FB_ADDR={fy,fx}, FB_DATA=FILL_VAL. fx/fy step with the same wrap rule as the cursor. After writing (X_MAX,Y_MAX) -> DONE.
  - DONE: FB_WE=0, BUSY<=0 -> IDLE. DONE lasts 1 cycle.
  - Fill duration is (X_MAX+1)*(Y_MAX+1) write cycles.
- While BUSY:
  - PIXEL writes are dropped and set DROP.
  - START is ignored.
  - COLOUR, X, Y, FILL and AUTOINC writes are accepted. FILL_VAL is sampled per cycle, so a mid-fill change takes effect immediately.
- DROP is sticky. CLR_DROP clears it. If CLR_DROP and a new drop happen in the same cycle, set wins.
- Read:
  - When BUS_WE=0 and BUS_ADDR is in the window, BUS_DATA_OE=1 on the next cycle, with BUS_DATA_OUT as below. Otherwise OE=0 and OUT=0.
  - +0 returns CONFIG_COL[15:8]. +1 returns X, zero-extended. +2 returns Y, zero-extended. +3 returns 0. +4 returns {5'b0, AUTOINC, DROP, BUSY}. +5 returns FILL_VAL, zero-extended.
- Addresses outside the window have no effect.
- Reset asserted mid-fill aborts immediately: FB_WE=0 and there is no DONE cycle.

Optional Feature:
- VGA_FILL_EN
  - Defined: fill FSM present as above.
  - Undefined: no FSM or fill counters. BUSY is tied 0 and START is ignored. FILL register writes are ignored and it reads 0. PIXEL writes are never dropped because of busy.

Decomposition:
- Shared package vga_pkg holds:
  - register offset constants: REG_COLOUR=0, REG_X=1, REG_Y=2, REG_PIXEL=3, REG_CTRL=4, REG_FILL=5;
  - CTRL/status bit-index constants;
  - fill state typedef {IDLE, FILL, DONE}.
- One natural sub-module: vga_xy_counter. It is a parametrised X/Y counter with wrap at X_MAX/Y_MAX and a frame-end flag. It is instantiated twice: once for the cursor, once for the fill engine.

Test Plan:
- Reset, then write BASE+0=8'h3C -> CONFIG_COL=16'h3CC3. Read BASE+0 -> OE=1 next cycle, OUT=8'h3C.
- AUTOINC=1, X=159, Y=5, PIXEL=1 -> FB_WE one cycle at addr {5,159}. Read X=0, Y=6. Repeat at Y=119 -> cursor wraps to (0,0).
- PIX_W=4, AUTOINC=0, X=10, Y=20, PIXEL=8'hFA -> FB_DATA=4'hA at {20,10}. Cursor unchanged.
- FILL=1, CTRL=1 -> BUSY=1, then 19200 consecutive FB_WE cycles, addresses 0..{119,159}, then BUSY=0. Status read mid-fill -> bit0=1.
- PIXEL write during fill -> no extra FB_WE, DROP=1. CTRL=4 -> DROP=0. Drop plus CLR_DROP in the same cycle -> DROP=1.
- Assert RESET mid-fill -> FB_WE=0 and BUSY=0 within the same cycle. All registers read 0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer bus controller: register window
// offsets, CTRL/status bit positions and the fill engine state type.
package vga_pkg;

    localparam logic [7:0] REG_COLOUR = 8'd0;
    localparam logic [7:0] REG_X      = 8'd1;
    localparam logic [7:0] REG_Y      = 8'd2;
    localparam logic [7:0] REG_PIXEL  = 8'd3;
    localparam logic [7:0] REG_CTRL   = 8'd4;
    localparam logic [7:0] REG_FILL   = 8'd5;
    localparam logic [7:0] REG_COUNT  = 8'd6;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_AUTOINC  = 1;
    localparam int CTRL_CLR_DROP = 2;

    // Status read-back bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DROP    = 1;
    localparam int STAT_AUTOINC = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/vga_xy_counter.sv
// X/Y raster counter: loadable coordinates, raster-order step with full-frame
// wrap at (X_MAX, Y_MAX), and a flag marking the last pixel of the frame.
module vga_xy_counter
    import vga_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clr,
    input  logic           i_step,
    input  logic           i_ld_x,
    input  logic           i_ld_y,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    // NOTE: state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end else begin
            if (i_ld_x) r_x <= i_x;
            if (i_ld_y) r_y <= i_y;
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/vga_fb_bus_ctrl.sv
// Bus-mapped frame-buffer write controller with cursor, status read-back and
// colour config. The hardware fill engine is built only when VGA_FILL_EN is defined.
module vga_fb_bus_ctrl
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         X_W       = 8,
    parameter int         Y_W       = 7,
    parameter int         PIX_W     = 1,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [7:0]           BUS_ADDR,
    input  logic [7:0]           BUS_DATA,
    input  logic                 BUS_WE,
    output logic [7:0]           BUS_DATA_OUT,
    output logic                 BUS_DATA_OE,
    output logic [X_W+Y_W-1:0]   FB_ADDR,
    output logic [PIX_W-1:0]     FB_DATA,
    output logic                 FB_WE,
    output logic [15:0]          CONFIG_COL,
    output logic                 BUSY
);

    logic [7:0]         w_off;
    logic               w_in_win, w_wr, w_rd;
    logic               w_wr_colour, w_wr_x, w_wr_y, w_wr_pixel, w_wr_ctrl, w_wr_fill;
    logic               w_busy, w_oob, w_pix_drop, w_pix_ok;
    logic [X_W-1:0]     w_cur_x;
    logic [Y_W-1:0]     w_cur_y;
    logic               w_fill_wr;
    logic [X_W+Y_W-1:0] w_fill_addr;
    logic [PIX_W-1:0]   w_fill_data, w_fill_rd;
    logic [7:0]         w_status, w_rd_data;

    logic [15:0]        r_config_col;
    logic               r_autoinc, r_drop;
    logic               r_fb_we;
    logic [X_W+Y_W-1:0] r_fb_addr;
    logic [PIX_W-1:0]   r_fb_data;
    logic               r_rd_oe;
    logic [7:0]         r_rd_data;

    // Offset wraps for addresses below BASE_ADDR, so one compare bounds the window.
    assign w_off       = BUS_ADDR - BASE_ADDR;
    assign w_in_win    = (w_off < REG_COUNT);
    assign w_wr        = BUS_WE & w_in_win;
    assign w_rd        = ~BUS_WE & w_in_win;
    assign w_wr_colour = w_wr && (w_off == REG_COLOUR);
    assign w_wr_x      = w_wr && (w_off == REG_X);
    assign w_wr_y      = w_wr && (w_off == REG_Y);
    assign w_wr_pixel  = w_wr && (w_off == REG_PIXEL);
    assign w_wr_ctrl   = w_wr && (w_off == REG_CTRL);
    assign w_wr_fill   = w_wr && (w_off == REG_FILL);

    assign w_oob      = (w_cur_x > X_W'(X_MAX)) || (w_cur_y > Y_W'(Y_MAX));
    assign w_pix_drop = w_wr_pixel & (w_oob | w_busy);
    assign w_pix_ok   = w_wr_pixel & ~w_pix_drop;

    vga_xy_counter #(.X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_cursor (
        .clk    (CLK),
        .rst_n  (RESET),
        .i_clr  (w_wr_pixel & w_oob & r_autoinc),
        .i_step (w_pix_ok & r_autoinc),
        .i_ld_x (w_wr_x),
        .i_ld_y (w_wr_y),
        .i_x    (BUS_DATA[X_W-1:0]),
        .i_y    (BUS_DATA[Y_W-1:0]),
        .o_x    (w_cur_x),
        .o_y    (w_cur_y),
        .o_last ()
    );

`ifdef VGA_FILL_EN
    fill_state_t      r_state, w_state_nxt;
    logic             w_fill_start, w_fill_step, w_fill_last;
    logic [X_W-1:0]   w_fx;
    logic [Y_W-1:0]   w_fy;
    logic [PIX_W-1:0] r_fill_val;

    assign w_busy       = (r_state != IDLE);
    assign w_fill_start = w_wr_ctrl & BUS_DATA[CTRL_START] & (r_state == IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_step = 1'b0;
        unique case (r_state)
            IDLE: if (w_fill_start) w_state_nxt = FILL;
            FILL: begin
                w_fill_step = 1'b1;
                if (w_fill_last) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    vga_xy_counter #(.X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_fill_cnt (
        .clk    (CLK),
        .rst_n  (RESET),
        .i_clr  (w_fill_start),
        .i_step (w_fill_step),
        .i_ld_x (1'b0),
        .i_ld_y (1'b0),
        .i_x    ('0),
        .i_y    ('0),
        .o_x    (w_fx),
        .o_y    (w_fy),
        .o_last (w_fill_last)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)         r_fill_val <= '0;
        else if (w_wr_fill) r_fill_val <= BUS_DATA[PIX_W-1:0];
    end

    assign w_fill_wr   = w_fill_step;
    assign w_fill_addr = {w_fy, w_fx};
    assign w_fill_data = r_fill_val;
    assign w_fill_rd   = r_fill_val;
`else
    assign w_busy      = 1'b0;
    assign w_fill_wr   = 1'b0;
    assign w_fill_addr = '0;
    assign w_fill_data = '0;
    assign w_fill_rd   = '0;
`endif

    always_comb begin
        w_status               = '0;
        w_status[STAT_BUSY]    = w_busy;
        w_status[STAT_DROP]    = r_drop;
        w_status[STAT_AUTOINC] = r_autoinc;
        w_rd_data              = '0;
        case (w_off)
            REG_COLOUR: w_rd_data = r_config_col[15:8];
            REG_X:      w_rd_data = 8'(w_cur_x);
            REG_Y:      w_rd_data = 8'(w_cur_y);
            REG_CTRL:   w_rd_data = w_status;
            REG_FILL:   w_rd_data = 8'(w_fill_rd);
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_config_col <= '0;
            r_autoinc    <= 1'b0;
            r_drop       <= 1'b0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_rd_oe      <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if (w_wr_colour) r_config_col <= {BUS_DATA, ~BUS_DATA};
            if (w_wr_ctrl)   r_autoinc    <= BUS_DATA[CTRL_AUTOINC];
            // A new drop outranks a simultaneous clear.
            if (w_pix_drop)                               r_drop <= 1'b1;
            else if (w_wr_ctrl && BUS_DATA[CTRL_CLR_DROP]) r_drop <= 1'b0;

            r_fb_we <= w_fill_wr | w_pix_ok;
            if (w_fill_wr) begin
                r_fb_addr <= w_fill_addr;
                r_fb_data <= w_fill_data;
            end else if (w_pix_ok) begin
                r_fb_addr <= {w_cur_y, w_cur_x};
                r_fb_data <= BUS_DATA[PIX_W-1:0];
            end

            r_rd_oe   <= w_rd;
            r_rd_data <= w_rd ? w_rd_data : 8'h00;
        end
    end

    assign CONFIG_COL   = r_config_col;
    assign FB_WE        = r_fb_we;
    assign FB_ADDR      = r_fb_addr;
    assign FB_DATA      = r_fb_data;
    assign BUS_DATA_OE  = r_rd_oe;
    assign BUS_DATA_OUT = r_rd_data;
    assign BUSY         = w_busy;

endmodule

// File: tb/tb_vga_fb_bus_ctrl.sv
// Self-checking bench for vga_fb_bus_ctrl: a frame-level reference model checked
// every cycle, plus directed bus sequences with literal expectations.
module tb_vga_fb_bus_ctrl;

    localparam logic [7:0] BASE  = 8'hB0;
    localparam int         X_W   = 8;
    localparam int         Y_W   = 7;
    localparam int         PIX_W = 4;
    localparam int         X_MAX = 159;
    localparam int         Y_MAX = 119;
    localparam int         PX    = X_MAX + 1;
    localparam int         FRAME = PX * (Y_MAX + 1);
`ifdef VGA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic               CLK   = 1'b0;
    logic               RESET = 1'b1;
    logic [7:0]         BUS_ADDR, BUS_DATA;
    logic               BUS_WE;
    logic [7:0]         BUS_DATA_OUT;
    logic               BUS_DATA_OE;
    logic [X_W+Y_W-1:0] FB_ADDR;
    logic [PIX_W-1:0]   FB_DATA;
    logic               FB_WE;
    logic [15:0]        CONFIG_COL;
    logic               BUSY;

    int total = 0;
    int bad   = 0;

    vga_fb_bus_ctrl #(
        .BASE_ADDR(BASE), .X_W(X_W), .Y_W(Y_W), .PIX_W(PIX_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_DATA     (BUS_DATA),
        .BUS_WE       (BUS_WE),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_DATA_OE  (BUS_DATA_OE),
        .FB_ADDR      (FB_ADDR),
        .FB_DATA      (FB_DATA),
        .FB_WE        (FB_WE),
        .CONFIG_COL   (CONFIG_COL),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference model: cursor as a raster index, fill as a write count 0..FRAME-1.
    logic [15:0] m_cfg;
    int          m_x, m_y, m_n, m_fill;   // m_fill: 0 idle, 1 writing, 2 finishing
    bit          m_auto, m_drop;
    logic [3:0]  m_fill_val;
    bit          exp_we, exp_oe;
    logic [14:0] exp_addr;
    logic [3:0]  exp_data;
    logic [7:0]  exp_out;

    task automatic model_reset();
        m_cfg = '0; m_x = 0; m_y = 0; m_n = 0; m_fill = 0;
        m_auto = 0; m_drop = 0; m_fill_val = '0;
        exp_we = 0; exp_oe = 0; exp_addr = '0; exp_data = '0; exp_out = '0;
    endtask

    task automatic model_step();
        int off, nfill, nn, idx;
        bit inwin, busy, oob, nwe;
        logic [14:0] naddr;
        logic [3:0]  ndata;
        off   = int'(BUS_ADDR) - int'(BASE);
        inwin = (off >= 0) && (off < 6);
        busy  = FILL_EN && (m_fill != 0);
        nfill = m_fill; nn = m_n; nwe = 0; naddr = exp_addr; ndata = exp_data;
        if (busy && m_fill == 1) begin
            nwe = 1;
            naddr = {7'(m_n / PX), 8'(m_n % PX)};
            ndata = m_fill_val;
            nn = m_n + 1;
            if (m_n == FRAME - 1) nfill = 2;
        end else if (m_fill == 2) begin
            nfill = 0;
        end
        exp_oe  = !BUS_WE && inwin;
        exp_out = '0;
        if (exp_oe) begin
            case (off)
                0: exp_out = m_cfg[15:8];
                1: exp_out = 8'(m_x);
                2: exp_out = 8'(m_y);
                4: exp_out = {5'd0, m_auto, m_drop, busy};
                5: exp_out = FILL_EN ? {4'd0, m_fill_val} : 8'd0;
                default: exp_out = '0;
            endcase
        end
        if (BUS_WE && inwin) begin
            case (off)
                0: m_cfg = {BUS_DATA, ~BUS_DATA};
                1: m_x = int'(BUS_DATA);
                2: m_y = int'(BUS_DATA) % 128;
                3: begin
                    oob = (m_x > X_MAX) || (m_y > Y_MAX);
                    if (busy || oob) begin
                        m_drop = 1;
                        if (oob && m_auto) begin m_x = 0; m_y = 0; end
                    end else begin
                        nwe = 1;
                        naddr = {7'(m_y), 8'(m_x)};
                        ndata = BUS_DATA[3:0];
                        if (m_auto) begin
                            idx = (m_y * PX + m_x + 1) % FRAME;
                            m_x = idx % PX;
                            m_y = idx / PX;
                        end
                    end
                end
                4: begin
                    m_auto = BUS_DATA[1];
                    if (BUS_DATA[2]) m_drop = 0;
                    if (BUS_DATA[0] && FILL_EN && m_fill == 0) begin nfill = 1; nn = 0; end
                end
                default: if (FILL_EN) m_fill_val = BUS_DATA[3:0];
            endcase
        end
        m_fill = nfill; m_n = nn;
        exp_we = nwe; exp_addr = naddr; exp_data = ndata;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) model_reset();
            else        model_step();
        end
    end

    int          we_cnt = 0;
    logic [14:0] last_we_addr = '0;

    initial begin
        forever begin
            @(negedge CLK);
            check("fb_we", 32'(FB_WE), 32'(exp_we));
            if (exp_we) begin
                check("fb_addr", 32'(FB_ADDR), 32'(exp_addr));
                check("fb_data", 32'(FB_DATA), 32'(exp_data));
            end
            check("busy", 32'(BUSY), 32'(FILL_EN && m_fill != 0));
            check("config_col", 32'(CONFIG_COL), 32'(m_cfg));
            check("rd_oe", 32'(BUS_DATA_OE), 32'(exp_oe));
            check("rd_data", 32'(BUS_DATA_OUT), 32'(exp_out));
            if (FB_WE) begin
                we_cnt++;
                last_we_addr = FB_ADDR;
            end
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a; BUS_DATA = d; BUS_WE = 1'b1;
        @(posedge CLK); #1;
        BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA = 8'h00;
    endtask

    task automatic bus_rd(input string name, input logic [7:0] a, input logic [7:0] want);
        BUS_ADDR = a; BUS_WE = 1'b0;
        @(posedge CLK); #1;
        check({name, "_oe"}, 32'(BUS_DATA_OE), 32'd1);
        check(name, 32'(BUS_DATA_OUT), 32'(want));
        BUS_ADDR = 8'h00;
    endtask

    task automatic reset_and_readback();
        #2 RESET = 1'b0;
        #1;
        check("rst_fb_we", 32'(FB_WE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("rst_cfg", 32'(CONFIG_COL), 32'd0);
        bus_rd("rst_colour", BASE + 8'd0, 8'h00);
        bus_rd("rst_x",      BASE + 8'd1, 8'h00);
        bus_rd("rst_y",      BASE + 8'd2, 8'h00);
        bus_rd("rst_pixel",  BASE + 8'd3, 8'h00);
        bus_rd("rst_status", BASE + 8'd4, 8'h00);
        bus_rd("rst_fill",   BASE + 8'd5, 8'h00);
    endtask

    initial begin
        int snap;
        BUS_ADDR = 8'h00; BUS_DATA = 8'h00; BUS_WE = 1'b0;
        #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_fb_we", 32'(FB_WE), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_cfg", 32'(CONFIG_COL), 32'd0);
        check("reset_oe", 32'(BUS_DATA_OE), 32'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        bus_wr(BASE + 8'd0, 8'h3C);
        check("colour_cfg", 32'(CONFIG_COL), 32'h3CC3);
        bus_rd("colour_rd", BASE + 8'd0, 8'h3C);

        // Auto-increment across a line end, then across the frame end
        bus_wr(BASE + 8'd4, 8'h02);
        bus_wr(BASE + 8'd1, 8'd159);
        bus_wr(BASE + 8'd2, 8'd5);
        bus_wr(BASE + 8'd3, 8'h01);
        check("pix1_we", 32'(FB_WE), 32'd1);
        check("pix1_addr", 32'(FB_ADDR), 32'({7'd5, 8'd159}));
        check("pix1_data", 32'(FB_DATA), 32'h1);
        bus_rd("ainc_x", BASE + 8'd1, 8'd0);
        bus_rd("ainc_y", BASE + 8'd2, 8'd6);
        bus_wr(BASE + 8'd1, 8'd159);
        bus_wr(BASE + 8'd2, 8'd119);
        bus_wr(BASE + 8'd3, 8'h01);
        check("pix2_addr", 32'(FB_ADDR), 32'({7'd119, 8'd159}));
        bus_rd("wrap_x", BASE + 8'd1, 8'd0);
        bus_rd("wrap_y", BASE + 8'd2, 8'd0);

        // Multi-bit pixel, no auto-increment
        bus_wr(BASE + 8'd4, 8'h00);
        bus_wr(BASE + 8'd1, 8'd10);
        bus_wr(BASE + 8'd2, 8'd20);
        bus_wr(BASE + 8'd3, 8'hFA);
        check("pix3_we", 32'(FB_WE), 32'd1);
        check("pix3_addr", 32'(FB_ADDR), 32'({7'd20, 8'd10}));
        check("pix3_data", 32'(FB_DATA), 32'hA);
        bus_rd("hold_x", BASE + 8'd1, 8'd10);
        bus_rd("hold_y", BASE + 8'd2, 8'd20);

        // Out-of-range cursor drops the write and sets the sticky DROP flag
        bus_wr(BASE + 8'd1, 8'd200);
        bus_wr(BASE + 8'd3, 8'h05);
        check("oob_we", 32'(FB_WE), 32'd0);
        bus_rd("oob_status", BASE + 8'd4, 8'h02);
        bus_wr(BASE + 8'd4, 8'h04);
        bus_rd("clr_status", BASE + 8'd4, 8'h00);
        bus_wr(BASE + 8'd4, 8'h02);
        bus_wr(BASE + 8'd1, 8'd170);
        bus_wr(BASE + 8'd2, 8'd3);
        bus_wr(BASE + 8'd3, 8'h05);
        bus_rd("oob_ainc_x", BASE + 8'd1, 8'd0);
        bus_rd("oob_ainc_y", BASE + 8'd2, 8'd0);
        bus_rd("oob_ainc_st", BASE + 8'd4, 8'h06);
        bus_wr(BASE + 8'd4, 8'h06);
        bus_rd("ainc_only_st", BASE + 8'd4, 8'h04);
        bus_wr(BASE + 8'd4, 8'h00);

        // Outside the window: no register change, no read drive
        bus_wr(8'hB6, 8'h55);
        bus_wr(8'hAF, 8'h55);
        check("outwin_cfg", 32'(CONFIG_COL), 32'h3CC3);
        BUS_ADDR = 8'hB6;
        @(posedge CLK); #1;
        check("outwin_oe", 32'(BUS_DATA_OE), 32'd0);
        check("outwin_out", 32'(BUS_DATA_OUT), 32'd0);
        BUS_ADDR = 8'h00;
        bus_rd("pixel_rd", BASE + 8'd3, 8'h00);

`ifdef VGA_FILL_EN
        bus_wr(BASE + 8'd5, 8'h03);
        bus_rd("fill_rd", BASE + 8'd5, 8'h03);
        bus_wr(BASE + 8'd4, 8'h01);
        check("fill_busy", 32'(BUSY), 32'd1);
        snap = we_cnt;
        bus_rd("mid_status", BASE + 8'd4, 8'h01);
        bus_wr(BASE + 8'd3, 8'h0F);
        bus_rd("busy_drop_st", BASE + 8'd4, 8'h03);
        bus_wr(BASE + 8'd4, 8'h04);
        bus_rd("busy_clr_st", BASE + 8'd4, 8'h01);
        bus_wr(BASE + 8'd5, 8'h05);
        for (int i = 0; i < 25000; i++) begin
            @(posedge CLK); #1;
            if (!BUSY) break;
        end
        check("fill_done", 32'(BUSY), 32'd0);
        check("fill_count", 32'(we_cnt - snap), 32'(FRAME));
        check("fill_last", 32'(last_we_addr), 32'({7'd119, 8'd159}));

        bus_wr(BASE + 8'd4, 8'h01);
        repeat (500) @(posedge CLK);
        #1;
        check("refill_busy", 32'(BUSY), 32'd1);
`else
        bus_wr(BASE + 8'd5, 8'h03);
        bus_rd("nofill_rd", BASE + 8'd5, 8'h00);
        bus_wr(BASE + 8'd4, 8'h01);
        check("nofill_busy", 32'(BUSY), 32'd0);
        @(posedge CLK); #1;
        check("nofill_we", 32'(FB_WE), 32'd0);
        bus_rd("nofill_status", BASE + 8'd4, 8'h00);
        snap = we_cnt;
        bus_wr(BASE + 8'd1, 8'd1);
        bus_wr(BASE + 8'd3, 8'h07);
        check("nofill_pix_we", 32'(FB_WE), 32'd1);
        @(posedge CLK); #1;
        check("nofill_pix_cnt", 32'(we_cnt - snap), 32'd1);
`endif
        reset_and_readback();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
